// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//   Owns the multiplexed address/data bus of the external RTC chip and
//   arbitrates it between two requesters (0: PicoBlaze port logic,
//   1: hardware time-refresh scanner). Each grant runs an address phase
//   (AD low) followed by a read or write data phase, then a recovery gap.
//   All RTC strobes are active-low and registered.
//
//   Build option: define RTC_ARB_RR_EN for round-robin arbitration;
//   otherwise requester 0 has fixed priority.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN   request level (held until doneN), write flag,
//                           RTC register address, write data
//   doneN                   one-cycle completion pulse
//   rdata                   read data, valid with done, held until next read
//   busy                    high whenever not IDLE
//   AD, CS, RD, WR          RTC control lines, active-low
//   bus_out, bus_oe         pad drive value / enable (tristate built above)
//   bus_in                  pad input value
module rtc_bus_sequencer #(
  parameter int T_SET   = 1,
  parameter int T_STB   = 2,
  parameter int T_HLD   = 1,
  parameter int T_RECOV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       done0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, RECOV
  } state_t;

  localparam logic [7:0] LD_SET   = 8'(T_SET - 1);
  localparam logic [7:0] LD_STB   = 8'(T_STB - 1);
  localparam logic [7:0] LD_HLD   = 8'(T_HLD - 1);
  localparam logic [7:0] LD_RECOV = 8'(T_RECOV - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       we_q, we_n;
  logic [7:0] addr_q, addr_n, wdata_q, wdata_n;
  logic       id_q, id_n;
  logic       win;
  logic       last;
  logic       a_ph, d_ph;

`ifdef RTC_ARB_RR_EN
  logic       rr_ptr;   // 1 = requester 1 wins a tie
`endif

  assign last = (cnt == 8'd0);

  // Next-state logic; outputs are decoded from the next state below so
  // that every pad signal comes straight from a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    id_n    = id_q;
`ifdef RTC_ARB_RR_EN
    win = req1 & (~req0 | rr_ptr);
`else
    win = ~req0;
`endif
    case (state)
      IDLE:
        if (req0 | req1) begin
          state_n = A_SET;
          cnt_n   = LD_SET;
          id_n    = win;
          we_n    = win ? we1    : we0;
          addr_n  = win ? addr1  : addr0;
          wdata_n = win ? wdata1 : wdata0;
        end
      A_SET:
        if (last) begin state_n = A_STB; cnt_n = LD_STB; end
        else cnt_n = cnt - 8'd1;
      A_STB:
        if (last) begin state_n = A_HLD; cnt_n = LD_HLD; end
        else cnt_n = cnt - 8'd1;
      A_HLD:
        if (last) begin state_n = D_SET; cnt_n = LD_SET; end
        else cnt_n = cnt - 8'd1;
      D_SET:
        if (last) begin state_n = D_STB; cnt_n = LD_STB; end
        else cnt_n = cnt - 8'd1;
      D_STB:
        if (last) begin state_n = D_HLD; cnt_n = LD_HLD; end
        else cnt_n = cnt - 8'd1;
      D_HLD:
        if (last) begin state_n = RECOV; cnt_n = LD_RECOV; end
        else cnt_n = cnt - 8'd1;
      RECOV:
        if (last) begin state_n = IDLE; cnt_n = 8'd0; end
        else cnt_n = cnt - 8'd1;
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign a_ph = (state_n == A_SET) || (state_n == A_STB) || (state_n == A_HLD);
  assign d_ph = (state_n == D_SET) || (state_n == D_STB) || (state_n == D_HLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      id_q    <= 1'b0;
      AD      <= 1'b1;
      CS      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= 8'd0;
      rdata   <= 8'd0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
`ifdef RTC_ARB_RR_EN
      rr_ptr  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      id_q    <= id_n;
      // Setup/hold states keep strobes high, so bus_oe and AD only ever
      // change while CS is released.
      AD      <= ~a_ph;
      CS      <= ~((state_n == A_STB) || (state_n == D_STB));
      WR      <= ~((state_n == A_STB) || ((state_n == D_STB) && we_n));
      RD      <= ~((state_n == D_STB) && !we_n);
      bus_oe  <= a_ph | (d_ph & we_n);
      bus_out <= a_ph ? addr_n : ((d_ph & we_n) ? wdata_n : 8'h00);
      busy    <= (state_n != IDLE);
      // done lands in the first RECOV cycle
      done0   <= (state == D_HLD) && last && !id_q;
      done1   <= (state == D_HLD) && last &&  id_q;
      if ((state == D_STB) && last && !we_q)
        rdata <= bus_in;
`ifdef RTC_ARB_RR_EN
      if ((state == IDLE) && (req0 | req1))
        rr_ptr <= ~win;
`endif
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: default-timing instance plus a
// second instance with T_SET=3, T_STB=5, T_HLD=2, T_RECOV=1.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic       done0, done1, busy, ad, cs, rd, wr, bus_oe;
  logic [7:0] rdata, bus_out, bus_in;
  logic [7:0] rd_val = 8'h59;
  assign bus_in = !rd ? rd_val : 8'hA5;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .busy(busy), .AD(ad), .CS(cs), .RD(rd), .WR(wr),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  // swept-timing instance
  logic       s_req0 = 0, s_we0 = 0;
  logic [7:0] s_addr0 = 0, s_wdata0 = 0;
  logic       s_done0, s_done1, s_busy, s_ad, s_cs, s_rd, s_wr, s_oe;
  logic [7:0] s_rdata, s_bus_out, s_bus_in;
  assign s_bus_in = !s_rd ? 8'h66 : 8'hA5;

  rtc_bus_sequencer #(.T_SET(3), .T_STB(5), .T_HLD(2), .T_RECOV(1)) dut2 (
    .clk(clk), .reset(reset),
    .req0(s_req0), .we0(s_we0), .addr0(s_addr0), .wdata0(s_wdata0), .done0(s_done0),
    .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00), .done1(s_done1),
    .rdata(s_rdata), .busy(s_busy), .AD(s_ad), .CS(s_cs), .RD(s_rd), .WR(s_wr),
    .bus_out(s_bus_out), .bus_oe(s_oe), .bus_in(s_bus_in)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // protocol monitor on both instances
  bit   mon_en = 0;
  int   viol_rdwr = 0, viol_adcs = 0;
  logic ad_p, cs_p, s_ad_p, s_cs_p;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rd && !wr) viol_rdwr++;
      if (!s_rd && !s_wr) viol_rdwr++;
      if ((ad != ad_p) && !(cs && cs_p)) viol_adcs++;
      if ((s_ad != s_ad_p) && !(s_cs && s_cs_p)) viol_adcs++;
    end
    ad_p = ad; cs_p = cs; s_ad_p = s_ad; s_cs_p = s_cs;
  end

  // per-transaction statistics for the default instance
  int         a_stb, d_stb, rd_lo, wr_lo, oe_d, d0_cyc, d1_cyc, d0_cnt, d1_cnt;
  logic [7:0] a_bus, d_bus;

  // Called just after the grant edge; cycle k is the k-th cycle after it.
  task automatic watch(input int n);
    a_stb = 0; d_stb = 0; rd_lo = 0; wr_lo = 0; oe_d = 0;
    d0_cyc = 0; d1_cyc = 0; d0_cnt = 0; d1_cnt = 0; a_bus = 0; d_bus = 0;
    for (int k = 1; k <= n; k++) begin
      if (!ad && !cs) begin a_stb++; a_bus = bus_out; end
      if (ad && !cs) begin d_stb++; if (bus_oe) d_bus = bus_out; end
      if (!rd) rd_lo++;
      if (!wr) wr_lo++;
      if (k >= 5 && k <= 8 && bus_oe) oe_d++;
      if (done0) begin d0_cnt++; d0_cyc = k; req0 = 0; end
      if (done1) begin d1_cnt++; d1_cyc = k; req1 = 0; end
      step();
    end
  endtask

  int   exp_id [4];
  int   g_id   [4];
  int   g_cyc  [4];
  int   ng, cnt5, sa, sd, scyc, scnt;
  logic prev_busy;

  initial begin
`ifdef RTC_ARB_RR_EN
    exp_id = '{0, 1, 0, 1};
`else
    exp_id = '{0, 0, 0, 0};
`endif
    g_id = '{0, 0, 0, 0};
    g_cyc = '{0, 0, 0, 0};

    // reset state
    step(); step();
    reset = 0;
    step();
    mon_en = 1;
    chk("rst_strobes", {ad, cs, rd, wr}, 4'b1111);
    chk("rst_oe", bus_oe, 0);
    chk("rst_bus_out", bus_out, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst2_state", {s_ad, s_cs, s_rd, s_wr, s_oe, s_busy}, 6'b111100);

    // single write, requester 0
    req0 = 1; we0 = 1; addr0 = 8'h21; wdata0 = 8'h45;
    step();
    watch(11);
    chk("wr_addr_stb", a_stb, 2);
    chk("wr_addr_bus", a_bus, 8'h21);
    chk("wr_data_stb", d_stb, 2);
    chk("wr_data_bus", d_bus, 8'h45);
    chk("wr_done_cyc", d0_cyc, 9);
    chk("wr_done_cnt", d0_cnt, 1);
    chk("wr_rd_low", rd_lo, 0);

    // single read, requester 1
    rd_val = 8'h59;
    req1 = 1; we1 = 0; addr1 = 8'h22;
    step();
    watch(11);
    chk("rd_oe_data", oe_d, 0);
    chk("rd_rd_low", rd_lo, 2);
    chk("rd_addr_bus", a_bus, 8'h22);
    chk("rd_done_cyc", d1_cyc, 9);
    chk("rd_done0_cnt", d0_cnt, 0);
    chk("rd_rdata", rdata, 8'h59);

    // simultaneous requests held through four grants
    reset = 1; step(); reset = 0; step();
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA0;
    req1 = 1; we1 = 1; addr1 = 8'h11; wdata1 = 8'hB1;
    ng = 0; prev_busy = busy;
    for (int k = 1; k <= 80 && ng < 4; k++) begin
      step();
      if (busy && !prev_busy) begin
        g_id[ng] = (bus_out == 8'h11) ? 1 : 0;
        g_cyc[ng] = k;
        ng++;
      end
      prev_busy = busy;
    end
    req0 = 0; req1 = 0;
    chk("arb_ngrants", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), g_id[i], exp_id[i]);
    // back-to-back spacing 2*(1+2+1)+2+1
    for (int i = 1; i < 4; i++)
      chk($sformatf("arb_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 11);
    for (int k = 0; k < 30 && busy; k++) step();
    chk("arb_drain_busy", busy, 0);

    // request pulsed for one cycle
    rd_val = 8'h3C;
    req0 = 1; we0 = 0; addr0 = 8'h30;
    step();
    req0 = 0;
    watch(14);
    chk("pulse_done_cnt", d0_cnt, 1);
    chk("pulse_done_cyc", d0_cyc, 9);
    chk("pulse_rdata", rdata, 8'h3C);

    // reset during D_STB of a write
    req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h77;
    step();
    for (int k = 0; k < 5; k++) step();
    chk("rst_mid_in_dstb", {ad, cs, wr, bus_oe}, 4'b1001);
    reset = 1; req0 = 0;
    step();
    chk("rst_mid_strobes", {ad, cs, wr, rd}, 4'b1111);
    chk("rst_mid_oe", bus_oe, 0);
    chk("rst_mid_busy", busy, 0);
    cnt5 = 0;
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      if (done0 || done1) cnt5++;
      step();
    end
    chk("rst_mid_no_done", cnt5, 0);
    req0 = 1; we0 = 1; addr0 = 8'h41; wdata0 = 8'h78;
    step();
    watch(11);
    chk("rst_mid_regrant_cyc", d0_cyc, 9);
    chk("rst_mid_regrant_bus", d_bus, 8'h78);

    // swept timing instance
    s_req0 = 1; s_we0 = 1; s_addr0 = 8'h21; s_wdata0 = 8'h45;
    step();
    sa = 0; sd = 0; scyc = 0; scnt = 0;
    for (int k = 1; k <= 26; k++) begin
      if (!s_ad && !s_cs) sa++;
      if (s_ad && !s_cs) sd++;
      if (s_done0) begin scnt++; scyc = k; s_req0 = 0; end
      step();
    end
    chk("sweep_addr_stb", sa, 5);
    chk("sweep_data_stb", sd, 5);
    chk("sweep_done_cyc", scyc, 21);
    chk("sweep_done_cnt", scnt, 1);

    chk("inv_rd_wr_excl", viol_rdwr, 0);
    chk("inv_ad_while_cs_high", viol_adcs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
